// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I front end.
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/rv32i_fetch_if.sv
// Instruction-memory request/response and decode handshake bundle for the fetch stage.
interface rv32i_fetch_if;
    import rv32i_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_pc4;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output dec_valid, dec_instr, dec_pc, dec_pc4,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  dec_valid, dec_instr, dec_pc, dec_pc4,
        output dec_ready
    );
endinterface

// File: rtl/rv32i_fetch_buf.sv
// Synchronous FIFO of {instr, pc} between instruction memory and decode.
module rv32i_fetch_buf
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/rv32i_fetch.sv
// RV32I instruction-fetch stage: PC register, in-order imem requests, decode buffer.
// Optional misaligned-target trap: RV32I_FETCH_MISALIGN_TRAP_EN.
//
// state | meaning
// RUN   | normal fetch, requests issued under the buffer-space rule
// FAULT | misaligned redirect target seen; no requests, late responses dropped
module rv32i_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   next_pc_i,
    input  logic              redirect_i,
    rv32i_fetch_if.master     bus,
    output logic              fault
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int SW = CW + 2;

    fetch_state_e    state_q, state_d;
    logic            live_q;
    logic [XLEN-1:0] fpc_q, rpc_q, target;
    logic [CW-1:0]   outst_q, drop_q, fifo_count;
    logic [SW-1:0]   in_use;
    logic            accept, rsp_drop, push, pop;
    fetch_entry_t    head, wentry;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = |next_pc_i[1:0];
    assign target     = next_pc_i;
`else
    assign target     = next_pc_i & ~32'h3;
`endif

    assign pop      = bus.dec_valid && bus.dec_ready;
    // Dropped responses still occupy a slot until they arrive.
    assign in_use   = SW'(outst_q) + SW'(drop_q) + SW'(fifo_count) - SW'(pop);
    assign bus.imem_req_valid = live_q && (state_q == RUN) && (in_use < SW'(BUF_DEPTH));
    assign bus.imem_req_addr  = fpc_q;
    assign accept   = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_drop = (drop_q != '0);
    assign push     = bus.imem_rsp_valid && !rsp_drop && !redirect_i && (state_q == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q  <= 1'b0;
            fpc_q   <= RESET_PC;
            rpc_q   <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            live_q <= 1'b1;
            if (redirect_i) begin
                fpc_q   <= target;
                rpc_q   <= target;
                outst_q <= '0;
                drop_q  <= drop_q + outst_q + CW'(accept) - CW'(bus.imem_rsp_valid);
            end else begin
                if (accept) fpc_q <= fpc_q + 32'd4;
                if (push)   rpc_q <= rpc_q + 32'd4;
                outst_q <= outst_q + CW'(accept) - CW'(push);
                if (bus.imem_rsp_valid && rsp_drop) drop_q <= drop_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
        if (redirect_i) state_d = misaligned ? FAULT : RUN;
`endif
    end

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    assign fault = (state_q == FAULT);
`else
    assign fault = 1'b0;
`endif

    assign wentry = '{instr: bus.imem_rsp_data, pc: rpc_q};

    rv32i_fetch_buf #(.DEPTH(BUF_DEPTH), .CW(CW)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect_i),
        .wdata (wentry),
        .rdata (head),
        .count (fifo_count)
    );

    assign bus.dec_valid = (fifo_count != '0);
    assign bus.dec_instr = head.instr;
    assign bus.dec_pc    = head.pc;
    assign bus.dec_pc4   = head.pc + 32'd4;
endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch with a latency-programmable in-order memory model.
module tb_rv32i_fetch;
    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc_i;
    logic        redirect_i;
    logic        fault;

    rv32i_fetch_if bus();

    rv32i_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .next_pc_i  (next_pc_i),
        .redirect_i (redirect_i),
        .bus        (bus),
        .fault      (fault)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       mq[$];
    logic [31:0] acc_addr[$], acc_edge[$];
    logic [31:0] dpc[$], dins[$], dpc4[$], dedge[$];
    int cyc = 0;
    int lat = 1;
    int rel = 0;
    int n_chk = 0;
    int n_pass = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observe handshakes with pre-edge values; memory requests are queued with their due edge.
    always @(posedge clk) begin
        if (rst) mq.delete();
        else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{bus.imem_req_addr, cyc + lat});
                acc_addr.push_back(bus.imem_req_addr);
                acc_edge.push_back(32'(cyc));
            end
            if (bus.dec_valid && bus.dec_ready) begin
                dpc.push_back(bus.dec_pc);
                dins.push_back(bus.dec_instr);
                dpc4.push_back(bus.dec_pc4);
                dedge.push_back(32'(cyc));
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mq[0].addr ^ KEY;
            void'(mq.pop_front());
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_i = 1'b0;
        next_pc_i = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.dec_ready = 1'b1;
        repeat (2) step();
        acc_addr.delete(); acc_edge.delete();
        dpc.delete(); dins.delete(); dpc4.delete(); dedge.delete();
        rst = 1'b0;
        rel = cyc;
    endtask

    initial begin
        rst = 1'b1;
        redirect_i = 1'b0;
        next_pc_i = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.dec_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0;
        repeat (2) step();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_req_addr",  bus.imem_req_addr, 32'h0);
        chk("rst_dec_valid", 32'(bus.dec_valid), 32'h0);
        chk("rst_dec_instr", bus.dec_instr, 32'h0);
        chk("rst_dec_pc",    bus.dec_pc, 32'h0);
        chk("rst_dec_pc4",   bus.dec_pc4, 32'h4);
        chk("rst_fault",     32'(fault), 32'h0);

        // Streaming with 1-cycle memory
        lat = 1;
        do_reset();
        repeat (12) step();
        chk("a_acc0", qget(acc_addr, 0), 32'h0);
        chk("a_acc1", qget(acc_addr, 1), 32'h4);
        chk("a_acc2", qget(acc_addr, 2), 32'h8);
        chk("a_acc3", qget(acc_addr, 3), 32'hC);
        chk("a_first_req", qget(acc_edge, 0), 32'(rel + 1));
        chk("a_req_b2b", qget(acc_edge, 3) - qget(acc_edge, 0), 32'd3);
        chk("a_dec_lat", qget(dedge, 0) - qget(acc_edge, 0), 32'd2);
        chk("a_dpc0", qget(dpc, 0), 32'h0);
        chk("a_dpc1", qget(dpc, 1), 32'h4);
        chk("a_dpc3", qget(dpc, 3), 32'hC);
        chk("a_dins2", qget(dins, 2), 32'h8 ^ KEY);
        chk("a_dpc4_1", qget(dpc4, 1), 32'h8);
        chk("a_dec_b2b", qget(dedge, 3) - qget(dedge, 0), 32'd3);

        // Asynchronous reset mid-stream
        rst = 1'b1;
        #1;
        chk("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("mid_rst_dec_valid", 32'(bus.dec_valid), 32'h0);

        // Decode back-pressure fills the buffer
        lat = 1;
        do_reset();
        bus.dec_ready = 1'b0;
        repeat (8) step();
        chk("b_acc_count", 32'(acc_addr.size()), 32'd2);
        chk("b_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("b_dec_valid", 32'(bus.dec_valid), 32'h1);
        chk("b_dec_pc",    bus.dec_pc, 32'h0);
        chk("b_dec_instr", bus.dec_instr, 32'h0 ^ KEY);
        bus.dec_ready = 1'b1;
        repeat (10) step();
        for (int i = 0; i < 5; i++)
            chk($sformatf("b_dpc%0d", i), qget(dpc, i), 32'(4 * i));

        // Memory not ready for 3 cycles while 0x8 is pending
        lat = 1;
        do_reset();
        repeat (3) step();
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("c_hold_valid", 32'(bus.imem_req_valid), 32'h1);
            chk("c_hold_addr", bus.imem_req_addr, 32'h8);
            step();
        end
        chk("c_acc_count_stall", 32'(acc_addr.size()), 32'd2);
        bus.imem_req_ready = 1'b1;
        step();
        chk("c_acc2", qget(acc_addr, 2), 32'h8);
        repeat (8) step();
        for (int i = 0; i < 4; i++)
            chk($sformatf("c_dpc%0d", i), qget(dpc, i), 32'(4 * i));

        // Redirect with two outstanding requests on a 3-cycle memory
        lat = 3;
        do_reset();
        repeat (3) step();
        chk("d_full", 32'(bus.imem_req_valid), 32'h0);
        chk("d_acc_count", 32'(acc_addr.size()), 32'd2);
        next_pc_i = 32'h100;
        redirect_i = 1'b1;
        step();
        redirect_i = 1'b0;
        chk("d_redir_addr", bus.imem_req_addr, 32'h100);
        repeat (14) step();
        chk("d_acc2", qget(acc_addr, 2), 32'h100);
        chk("d_dpc0", qget(dpc, 0), 32'h100);
        chk("d_dins0", qget(dins, 0), 32'h100 ^ KEY);
        chk("d_dpc1", qget(dpc, 1), 32'h104);

        // Redirect coinciding with a response, an accept and a decode pop
        lat = 1;
        do_reset();
        repeat (4) step();
        #1;
        chk("e_pre_rsp", 32'(bus.imem_rsp_valid), 32'h1);
        chk("e_pre_req", 32'(bus.imem_req_valid), 32'h1);
        next_pc_i = 32'h200;
        redirect_i = 1'b1;
        step();
        redirect_i = 1'b0;
        chk("e_redir_addr", bus.imem_req_addr, 32'h200);
        repeat (8) step();
        chk("e_acc3", qget(acc_addr, 3), 32'hC);
        chk("e_acc4", qget(acc_addr, 4), 32'h200);
        chk("e_dpc1", qget(dpc, 1), 32'h4);
        chk("e_dpc2", qget(dpc, 2), 32'h200);
        chk("e_dpc3", qget(dpc, 3), 32'h204);

        // Misaligned redirect target
        lat = 1;
        do_reset();
        repeat (4) step();
        next_pc_i = 32'h102;
        redirect_i = 1'b1;
        step();
        redirect_i = 1'b0;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
        chk("f_fault_set", 32'(fault), 32'h1);
        chk("f_no_req", 32'(bus.imem_req_valid), 32'h0);
        begin
            int n_acc;
            n_acc = acc_addr.size();
            repeat (6) step();
            chk("f_acc_frozen", 32'(acc_addr.size()), 32'(n_acc));
        end
        chk("f_fifo_empty", 32'(bus.dec_valid), 32'h0);
        chk("f_fault_hold", 32'(fault), 32'h1);
        next_pc_i = 32'h200;
        redirect_i = 1'b1;
        step();
        redirect_i = 1'b0;
        chk("f_fault_clr", 32'(fault), 32'h0);
        chk("f_addr", bus.imem_req_addr, 32'h200);
        repeat (8) step();
        chk("f_dpc2", qget(dpc, 2), 32'h200);
`else
        chk("f_fault_tied", 32'(fault), 32'h0);
        chk("f_addr_aligned", bus.imem_req_addr, 32'h100);
        repeat (8) step();
        chk("f_dpc2", qget(dpc, 2), 32'h100);
        chk("f_dpc3", qget(dpc, 3), 32'h104);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rv32i_fetch.md
# rv32i_fetch

Instruction-fetch stage of the RV32I core. It holds the fetch program counter and loads it from the PC-select mux output whenever a branch, JAL or JALR is taken. It issues in-order requests to instruction memory over a valid/ready handshake and buffers the returned words. Instructions go to decode with their PC, and PC+4 is fed back as the mux's sequential input.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- BUF_DEPTH, 2, instruction buffer entries; power of two, ≥2

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- next_pc_i  in  32  selected target from PC-select mux
- redirect_i  in  1  taken branch/JAL/JALR; load next_pc_i, flush
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address (word aligned)
- imem_rsp_valid  in  1  response word valid, in request order, ≥1 cycle after accept
- imem_rsp_data  in  32  instruction word
- dec_valid  out  1  buffered instruction available
- dec_ready  in  1  decode consumes instruction
- dec_instr  out  32  instruction at buffer head
- dec_pc  out  32  PC of dec_instr
- dec_pc4  out  32  dec_pc + 4, mod 2^32 (mux sequential input)
- fault  out  1  misaligned target (only with macro; tied 0 otherwise)

## Operation
- Registers: fpc (next address to request), outstanding count, drop count, FIFO of {instr, pc}.
- States: RUN, FAULT. Reset enters RUN.
- Issue rule: imem_req_valid = RUN && (outstanding + fifo_count − pop) < BUF_DEPTH, where pop = dec_valid && dec_ready.
- Accept (valid && ready): fpc += 4 (wraps mod 2^32); outstanding += 1.
- Response: while drop count > 0, discard the word and decrement drop count. Otherwise push {imem_rsp_data, pc of that request} and decrement outstanding. The buffer never overflows.
- dec_* shows the FIFO head; dec_valid = FIFO non-empty.
- Redirect (highest priority):
  - fpc ← next_pc_i.
  - FIFO cleared.
  - drop count ← drop count + outstanding after this cycle's accept and response.
  - outstanding ← 0.
  - A response in the same cycle is discarded.
  - A request accepted in the same cycle goes out at the old address and is counted for drop.
  - A decode handshake in the same cycle counts as consumed.
- While drop count > 0, issuing continues under the issue rule; drop count is included in the outstanding term.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, dec_valid 0, dec_instr 0, dec_pc 0, dec_pc4 4, fault 0, counters 0.
- First request: cycle after rst deasserts.
- imem_req_addr = fpc. It is held stable while valid && !ready, except on redirect.
- Response-to-dec_valid latency: 1 cycle (registered FIFO, no bypass).
- Redirect-to-request: next_pc_i appears on imem_req_addr the cycle after redirect_i.
- Throughput: 1 instr/cycle with 1-cycle memory and dec_ready high.
- Reset mid-operation: all state cleared immediately. In-flight memory responses after reset are the memory's responsibility to squash.

## Configuration
- RV32I_FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with next_pc_i[1:0] ≠ 0 enters FAULT.
  - fault = 1, no requests issued, FIFO stays empty, late responses are dropped.
  - FAULT exits on an aligned redirect (back to RUN) or on reset.
- Not defined: next_pc_i[1:0] forced to 00, fault tied 0, and FAULT does not exist.

## Structure
- Package rv32i_pkg:
  - XLEN = 32
  - RESET_PC default
  - NOP = 32'h0000_0013
  - state enum {RUN, FAULT}
- Sub-module rv32i_fetch_buf: BUF_DEPTH-entry synchronous FIFO of {instr, pc} with push, pop, clear, count.

## Test plan
- Reset, 1-cycle memory, dec_ready=1:
  - Requests at 0x0, 0x4, 0x8, … on consecutive cycles.
  - dec_pc follows one per cycle; dec_pc4 = dec_pc + 4.
- dec_ready=0:
  - FIFO fills to BUF_DEPTH, then imem_req_valid drops.
  - Raising dec_ready resumes in order with no loss or duplicate.
- imem_req_ready low for 3 cycles: imem_req_addr is held at 0x8 until accepted.
- Redirect to 0x100 with 2 outstanding (3-cycle memory):
  - Both stale responses are discarded.
  - Next dec_pc = 0x100.
- Redirect in the same cycle as rsp_valid and a request accept: the response is dropped, the accepted request is dropped later, and fetch resumes at the target.
- With the macro, redirect to 0x102: fault=1 and no requests are issued. A later redirect to 0x200 clears fault and fetches 0x200.
